// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
// Limit-mode selectors and a width helper for instantiating blocks.
package counter_pkg;

   localparam int COUNT_WRAP = 0;
   localparam int COUNT_SAT  = 1;

   // Smallest width (in bits) that can hold the value max.
   function automatic int count_width(input logic [63:0] max);
      int w;
      w = 1;
      while (w < 64 && ((64'd1 << w) <= max))
         w++;
      return w;
   endfunction

endpackage

// File: rtl/counter_mod_next.sv
// Next-state logic for counter_mod: load clamp, count, wrap/saturate.
// Purely combinational; also produces the cascade terminal count.
module counter_mod_next
   import counter_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter logic [63:0] MAX   = (64'd1 << WIDTH) - 64'd1,
   parameter int          SAT   = COUNT_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             limit_hit,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];

   logic at_top;
   logic at_bot;
   logic do_up;
   logic do_dn;

   assign at_top = (q == MAXV);
   assign at_bot = (q == '0);
   assign do_up  = ~ld & en & up;
   assign do_dn  = ~ld & en & ~up;

   // Terminal count is not gated by ld; it feeds the next stage's en.
   assign tc = en & ((up & at_top) | (~up & at_bot));

   // Select exactly one action: load, step up, step down, or hold.
   always_comb begin
      next_q    = q;
      limit_hit = 1'b0;
      unique case (1'b1)
         ld: begin
            next_q = (d > MAXV) ? MAXV : d;
         end
         do_up: begin
            if (at_top) begin
               limit_hit = 1'b1;
               next_q    = (SAT == COUNT_SAT) ? q : '0;
            end else begin
               next_q = q + 1'b1;
            end
         end
         do_dn: begin
            if (at_bot) begin
               limit_hit = 1'b1;
               next_q    = (SAT == COUNT_SAT) ? q : MAXV;
            end else begin
               next_q = q - 1'b1;
            end
         end
         default: begin
            next_q    = q;
            limit_hit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/counter_mod.sv
// Parametrised up/down counter with load, wrap/saturate and cascade tc.
// Holds only the q and ovf registers; clr overrides everything.
module counter_mod
   import counter_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter logic [63:0] MAX   = (64'd1 << WIDTH) - 64'd1,
   parameter int          SAT   = COUNT_WRAP
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_mod: WIDTH out of range");
   end
   if (MAX == 64'd0 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("counter_mod: MAX out of range");
   end

   logic [WIDTH-1:0] next_q;
   logic             limit_hit;

   counter_mod_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX),
      .SAT   (SAT)
   ) u_next (
      .q         (q),
      .up        (up),
      .en        (en),
      .ld        (ld),
      .d         (d),
      .next_q    (next_q),
      .limit_hit (limit_hit),
      .tc        (tc)
   );

   // Count register and one-cycle limit pulse, synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         q   <= next_q;
         ovf <= limit_hit;
      end
   end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap, saturate, load, priority, cascade.
// Expected values are hand-computed from the counter's behaviour.
module tb_counter_mod;

   logic clk;
   int   n_cmp;
   int   n_bad;

   // Wrap instance (MAX=9, SAT=0)
   logic       w_clr, w_en, w_up, w_ld;
   logic [3:0] w_d, w_q;
   logic       w_tc, w_ovf;

   // Saturate instance (MAX=9, SAT=1)
   logic       s_clr, s_en, s_up, s_ld;
   logic [3:0] s_d, s_q;
   logic       s_tc, s_ovf;

   // Cascade pair
   logic       c_clr, c_en;
   logic [3:0] lo_q, hi_q;
   logic       lo_tc, lo_ovf, hi_tc, hi_ovf;
   logic [3:0] c_d;

   counter_mod #(.WIDTH(4), .MAX(9), .SAT(0)) u_wrap (
      .clk(clk), .clr(w_clr), .en(w_en), .up(w_up), .ld(w_ld),
      .d(w_d), .q(w_q), .tc(w_tc), .ovf(w_ovf)
   );

   counter_mod #(.WIDTH(4), .MAX(9), .SAT(1)) u_sat (
      .clk(clk), .clr(s_clr), .en(s_en), .up(s_up), .ld(s_ld),
      .d(s_d), .q(s_q), .tc(s_tc), .ovf(s_ovf)
   );

   counter_mod #(.WIDTH(4), .MAX(9), .SAT(0)) u_lo (
      .clk(clk), .clr(c_clr), .en(c_en), .up(1'b1), .ld(1'b0),
      .d(c_d), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf)
   );

   counter_mod #(.WIDTH(4), .MAX(9), .SAT(0)) u_hi (
      .clk(clk), .clr(c_clr), .en(lo_tc), .up(1'b1), .ld(1'b0),
      .d(c_d), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lo_exp;
      int hi_exp;
      int pulses;
      n_cmp = 0;
      n_bad = 0;
      pulses = 0;
      c_d = 4'd0;

      // Test 1: wrap count up from reset
      w_clr = 1; w_en = 0; w_up = 1; w_ld = 0; w_d = 0;
      tick();
      chk("w_rst_q", 32'(w_q), 0);
      chk("w_rst_ovf", 32'(w_ovf), 0);
      w_clr = 0; w_en = 1; w_up = 1;
      #1;
      chk("w_tc_up0", 32'(w_tc), 0);
      for (int i = 1; i <= 11; i++) begin
         tick();
         chk("w_up_q", 32'(w_q), 32'(i % 10));
         chk("w_up_ovf", 32'(w_ovf), 32'(i == 10));
         chk("w_up_tc", 32'(w_tc), 32'((i % 10) == 9));
      end

      // Test 2: wrap count down from reset
      w_clr = 1;
      tick();
      w_clr = 0; w_up = 0; w_en = 1;
      #1;
      chk("w_tc_dn0", 32'(w_tc), 1);
      tick();
      chk("w_dn_q9", 32'(w_q), 9);
      chk("w_dn_ovf", 32'(w_ovf), 1);
      chk("w_dn_tc9", 32'(w_tc), 0);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("w_dn_q", 32'(w_q), 32'(9 - k));
         chk("w_dn_ovf0", 32'(w_ovf), 0);
         chk("w_dn_tc", 32'(w_tc), 32'(k == 9));
      end

      // Test 4: load with clamp, load beats en, then hold
      w_ld = 1; w_d = 4'd12; w_en = 0; w_up = 1;
      tick();
      chk("ld_clamp", 32'(w_q), 9);
      w_d = 4'd5; w_en = 1; w_up = 1;
      #1;
      chk("tc_ungated_ld", 32'(w_tc), 1);
      tick();
      chk("ld_over_en", 32'(w_q), 5);
      chk("ld_ovf", 32'(w_ovf), 0);
      w_ld = 0; w_en = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("hold_q", 32'(w_q), 5);
         chk("hold_ovf", 32'(w_ovf), 0);
      end
      chk("hold_tc", 32'(w_tc), 0);

      // Test 5: priority clr > ld > en
      w_ld = 1; w_d = 4'd7;
      tick();
      chk("pri_pre", 32'(w_q), 7);
      w_clr = 1; w_ld = 1; w_d = 4'd3; w_en = 1; w_up = 1;
      tick();
      chk("pri_q", 32'(w_q), 0);
      chk("pri_ovf", 32'(w_ovf), 0);
      w_clr = 0; w_ld = 0;
      tick();
      tick();
      chk("mid_pre", 32'(w_q), 2);
      w_clr = 1;
      tick();
      chk("mid_clr", 32'(w_q), 0);
      w_clr = 0; w_ld = 1; w_d = 4'd9;
      tick();
      w_ld = 0; w_clr = 1; w_en = 1; w_up = 1;
      tick();
      chk("wrap_clr_q", 32'(w_q), 0);
      chk("wrap_clr_ovf", 32'(w_ovf), 0);
      w_clr = 0;

      // Test 3: saturate up, hold at MAX, then step down
      s_clr = 1; s_en = 0; s_up = 1; s_ld = 0; s_d = 0;
      tick();
      chk("s_rst_q", 32'(s_q), 0);
      s_clr = 0; s_en = 1; s_up = 1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk("s_up_q", 32'(s_q), 32'(i));
         chk("s_up_ovf", 32'(s_ovf), 0);
      end
      chk("s_tc", 32'(s_tc), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("s_hold_q", 32'(s_q), 9);
         chk("s_hold_ovf", 32'(s_ovf), 1);
      end
      s_up = 0;
      tick();
      chk("s_dn_q", 32'(s_q), 8);
      chk("s_dn_ovf", 32'(s_ovf), 0);
      s_clr = 1;
      tick();
      s_clr = 0; s_up = 0;
      tick();
      chk("s_bot_q", 32'(s_q), 0);
      chk("s_bot_ovf", 32'(s_ovf), 1);

      // Test 6: two-digit BCD cascade
      c_clr = 1; c_en = 0;
      tick();
      chk("c_rst", 32'({hi_q, lo_q}), 0);
      c_clr = 0; c_en = 1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         lo_exp = i % 10;
         hi_exp = (i % 100) / 10;
         chk("c_bcd", 32'({hi_q, lo_q}), 32'((hi_exp << 4) | lo_exp));
         chk("c_hi_ovf", 32'(hi_ovf), 32'(i == 100));
         chk("c_hi_tc", 32'(hi_tc), 32'((i % 100) == 99));
         chk("c_lo_ovf", 32'(lo_ovf), 32'(lo_exp == 0));
         if (hi_ovf) pulses++;
      end
      chk("c_pulses", 32'(pulses), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
